pipelined_add_sub: RTL and testbench

Parametrised, pipelined add/subtract/increment/decrement unit with a valid/ready handshake. It is the sequential successor to the combinational 8/32-bit add-sub and inc-dec blocks. Operands are split into STAGES equal chunks, and each pipeline stage resolves one chunk's sum with the carry registered into the next stage, so width scales without a long combinational carry chain. It sits between the register-read stage and writeback in the datapath and returns one result per cycle, with carry, signed-overflow and zero flags.

---
 rtl/pipelined_add_sub.sv | 136 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub/inc/dec unit: operands split into STAGES chunks of CW bits,
// one chunk resolved per stage with the carry registered between stages.
// A single global advance signal stalls every stage while the output is held.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned CW = WIDTH / STAGES;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_DEC = 2'b11
    } op_e;

    op_e              op;
    logic             advance;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;

    assign op       = op_e'(in_op);
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Map the operation onto a plain adder: effective B operand and carry-in
    always_comb begin
        b_sel   = in_b;
        cin_sel = 1'b0;
        case (op)
            OP_ADD: begin b_sel = in_b;  cin_sel = 1'b0; end
            OP_SUB: begin b_sel = ~in_b; cin_sel = 1'b1; end
            OP_INC: begin b_sel = '0;    cin_sel = 1'b1; end
            OP_DEC: begin b_sel = '1;    cin_sel = 1'b0; end
        endcase
    end

    // Operand registers narrow by one chunk per stage: stage k sees only the
    // not-yet-consumed chunks (its own chunk in the low CW bits), while the
    // resolved result grows by one chunk per stage until it is full width.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned IW = WIDTH - k * CW;
        localparam int unsigned SW = (k + 1) * CW;

        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   chunk;
        logic [SW-1:0] s_next;
        logic [SW-1:0] s_q;
        logic          c_q;
        logic          v_q;

        if (k == 0) begin : g_head
            assign a_in   = in_a;
            assign b_in   = b_sel;
            assign c_in   = cin_sel;
            assign v_in   = in_valid & advance;
            assign s_next = chunk[CW-1:0];
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign s_next = {chunk[CW-1:0], g_stage[k-1].s_q};
        end

        assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        // Partial sum, chunk carry and valid bit for this stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_next;
                c_q <= chunk[CW];
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-CW-1:0] a_q;
            logic [IW-CW-1:0] b_q;

            // Skew the remaining operand chunks forward to the stage that consumes them
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[IW-1:CW];
                    b_q <= b_in[IW-1:CW];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            // Signed overflow (carry into MSB xor carry out) and zero flag of the full result
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= chunk[CW] ^ s_next[SW-1] ^ a_in[CW-1] ^ b_in[CW-1];
                    zero_q <= ~|s_next;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign out_sum   = g_stage[STAGES-1].s_q;
    assign out_cout  = g_stage[STAGES-1].c_q;
    assign out_ovf   = g_stage[STAGES-1].g_last.ovf_q;
    assign out_zero  = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Testbench for pipelined_add_sub: directed corner cases, back-pressure,
// randomized traffic against an arithmetic reference model, and mid-flight reset.
module tb_pipelined_add_sub;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   n_retired = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        res_t            r;
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ur;
        longint          sr;
        case (op)
            2'd0: begin ur = ua + ub; sr = sa + sb; r.cout = (ur >= 64'h1_0000_0000); end
            2'd1: begin ur = ua - ub; sr = sa - sb; r.cout = (ua >= ub); end
            2'd2: begin ur = ua + 1;  sr = sa + 1;  r.cout = (ur >= 64'h1_0000_0000); end
            default: begin ur = ua - 1; sr = sa - 1; r.cout = (ua >= 1); end
        endcase
        r.sum  = ur[31:0];
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.sum == 32'h0);
        return r;
    endfunction

    // Scoreboard: retire and compare, then record newly accepted beats
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_sum",  out_sum,  mon_e.sum);
                    check("sb_cout", out_cout, mon_e.cout);
                    check("sb_ovf",  out_ovf,  mon_e.ovf);
                    check("sb_zero", out_zero, mon_e.zero);
                    n_retired++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_op));
        end
    end

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int guard = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [31:0] es, input logic ec,
                            input logic eo);
        int lat = 1;
        send(a, b, op);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},  lat,      STAGES);
        check({tag, "_sum"},  out_sum,  es);
        check({tag, "_cout"}, out_cout, ec);
        check({tag, "_ovf"},  out_ovf,  eo);
        check({tag, "_zero"}, out_zero, (es == 32'h0));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag, input int r0, input int n);
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_count"}, n_retired - r0, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0;
        logic [31:0] held;
        int g;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_sum",   out_sum,   32'h0);
        check("rst_cout",  out_cout,  1'b0);
        check("rst_ovf",   out_ovf,   1'b0);
        check("rst_zero",  out_zero,  1'b0);
        check("rst_ready", in_ready,  1'b1);
        rst_n = 1'b1;

        directed("add_ff",     32'h0000_00FF, 32'h0000_0001, 2'd0, 32'h0000_0100, 1'b0, 1'b0);
        directed("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_neg",    32'h0000_0005, 32'h0000_0007, 2'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf",    32'h8000_0000, 32'h0000_0001, 2'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("inc_ovf",    32'h7FFF_FFFF, 32'hDEAD_BEEF, 2'd2, 32'h8000_0000, 1'b0, 1'b1);
        directed("dec_zero",   32'h0000_0000, 32'hDEAD_BEEF, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        directed("inc_wrap",   32'hFFFF_FFFF, 32'hDEAD_BEEF, 2'd2, 32'h0000_0000, 1'b1, 1'b0);
        directed("dec_one",    32'h0000_0001, 32'hDEAD_BEEF, 2'd3, 32'h0000_0000, 1'b1, 1'b0);

        // Back-pressure: 8 back-to-back beats, 3-cycle stall at the first result
        r0 = n_retired;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom, $urandom, 2'($urandom));
            end
            begin
                g = 0;
                while (!out_valid && g < 50) begin
                    @(posedge clk); #1;
                    g++;
                end
                check("bp_first_valid", out_valid, 1'b1);
                out_ready = 1'b0;
                held = out_sum;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_hold_sum", out_sum, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("bp", r0, 8);

        // Random traffic with random back-pressure and input gaps
        r0 = n_retired;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send($urandom, $urandom, 2'($urandom));
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                end
            end
            begin
                repeat (80) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("rnd", r0, 40);

        // Reset with 3 beats in flight, the oldest held at the output
        send(32'h0000_0010, 32'h0000_0020, 2'd0);
        send(32'h0000_1234, 32'h0000_0001, 2'd1);
        send(32'h0000_0099, 32'h0000_0000, 2'd2);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", out_valid, 1'b0);
        check("mid_sum",   out_sum,   32'h0);
        check("mid_cout",  out_cout,  1'b0);
        check("mid_ovf",   out_ovf,   1'b0);
        check("mid_zero",  out_zero,  1'b0);
        check("mid_ready", in_ready,  1'b1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        r0 = n_retired;
        directed("post_rst", 32'h0000_0002, 32'h0000_0003, 2'd0, 32'h0000_0005, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle",  out_valid, 1'b0);
        check("post_rst_count", n_retired - r0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
